inst_fetch_unit: RTL and testbench

Instruction fetch front end for the CPU core. Owns the program counter, fetches instruction words from instruction memory over a variable-latency req/ack handshake, and buffers `{pc, inst}` pairs in a small FIFO. It presents them to decode through a valid/ready interface. Branch and jump redirects from execute flush the buffer and restart fetch at the new target.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_fetch_fifo.sv | 53 +++++
 rtl/inst_fetch_unit.sv | 122 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, fetch state encodings and PC helpers for the instruction fetch front end.
package inst_fetch_unit_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam logic [ADDR_LEN-1:0] PC_STEP = ADDR_LEN'(4);

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'b00,
    FETCH_FETCH = 2'b01,
    FETCH_STALL = 2'b10,
    FETCH_DROP  = 2'b11
  } fetch_state_e;

  function automatic logic [ADDR_LEN-1:0] align_pc(input logic [ADDR_LEN-1:0] pc);
    return {pc[ADDR_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Circular-buffer FIFO holding {pc, inst} pairs; head is a registered value, zero when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees the slot first, so a push into a full buffer is legal alongside it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: PC state machine issuing one imem request at a time into a small buffer.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_LEN-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                o_imem_req,
  output logic [ADDR_LEN-1:0] o_imem_addr,
  input  logic                i_imem_ack,
  input  logic [DATA_LEN-1:0] i_imem_rdata,
  input  logic                i_redirect_valid,
  input  logic [ADDR_LEN-1:0] i_redirect_pc,
  output logic                o_inst_valid,
  output logic [DATA_LEN-1:0] o_inst,
  output logic [ADDR_LEN-1:0] o_inst_pc,
  input  logic                i_inst_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ADDR_LEN + DATA_LEN;

  fetch_state_e        r_state;
  logic                r_imem_req;
  logic [ADDR_LEN-1:0] r_req_pc;
  logic [ADDR_LEN-1:0] r_fetch_pc;

  logic                w_ack;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_cnt_after_push;
  logic [FW-1:0]       w_head;
  logic [ADDR_LEN-1:0] w_target;

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_req_pc;

  // An ack outside an open request is meaningless and is ignored.
  assign w_ack            = i_imem_ack && r_imem_req;
  assign w_pop            = o_inst_valid && i_inst_ready;
  assign w_push           = (r_state == FETCH_FETCH) && w_ack && !i_redirect_valid;
  assign w_target         = align_pc(i_redirect_pc);
  assign w_cnt_after_push = w_count + CW'(1) - CW'(w_pop);

  assign o_inst_valid = !w_empty;
  assign o_inst_pc    = w_head[FW-1 -: ADDR_LEN];
  assign o_inst       = w_head[DATA_LEN-1:0];

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_redirect_valid),
    .i_push  (w_push),
    .i_data  ({r_req_pc, i_imem_rdata}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= FETCH_IDLE;
      r_imem_req <= 1'b0;
      r_req_pc   <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      // An open request cannot be withdrawn: keep its address and park the target.
      r_fetch_pc <= w_target;
      r_imem_req <= 1'b1;
      if (r_imem_req && !w_ack) begin
        r_state <= FETCH_DROP;
      end else begin
        r_state  <= FETCH_FETCH;
        r_req_pc <= w_target;
      end
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          r_state    <= FETCH_FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH_FETCH: begin
          if (w_ack) begin
            r_req_pc   <= r_req_pc + PC_STEP;
            r_fetch_pc <= r_req_pc + PC_STEP;
            if (w_cnt_after_push >= CW'(FIFO_DEPTH)) begin
              r_state    <= FETCH_STALL;
              r_imem_req <= 1'b0;
            end
          end
        end
        FETCH_STALL: begin
          if (!w_full || w_pop) begin
            r_state    <= FETCH_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        FETCH_DROP: begin
          if (w_ack) begin
            r_state  <= FETCH_FETCH;
            r_req_pc <= r_fetch_pc;
          end
        end
        default: begin
          r_state    <= FETCH_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench with a latency-configurable memory model and an {pc, inst} scoreboard.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  logic [63:0] sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_acks = 0;
  int          wait_cnt = 0;
  int          mem_lat = 0;
  int          acks0;
  bit          found;
  bit          drop_pending = 1'b0;
  bit          rogue_ack = 1'b0;
  logic [31:0] exp_req_pc = RST_PC;
  logic [31:0] drop_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory response, scoreboard push, consumer check at negedge.
  task automatic cycle();
    int          pushed_now;
    int          avail;
    bit          ack_now;
    bit          req_now;
    logic [63:0] e;
    pushed_now = 0;
    ack_now    = 1'b0;
    req_now    = o_imem_req;
    i_imem_ack = 1'b0;
    if (req_now) begin
      chk("imem_addr", o_imem_addr, exp_req_pc);
      if (rst && wait_cnt >= mem_lat) begin
        ack_now      = 1'b1;
        i_imem_ack   = 1'b1;
        i_imem_rdata = mem_word(o_imem_addr);
      end
    end else if (rogue_ack) begin
      i_imem_ack   = 1'b1;
      i_imem_rdata = 32'hDEAD_BEEF;
    end
    if (ack_now) begin
      n_acks++;
      if (drop_pending) begin
        drop_pending = 1'b0;
        exp_req_pc   = drop_target;
      end else if (!i_redirect_valid) begin
        sb.push_back({exp_req_pc, mem_word(exp_req_pc)});
        pushed_now = 1;
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
    if (i_redirect_valid) begin
      if (req_now && !ack_now) begin
        drop_pending = 1'b1;
        drop_target  = {i_redirect_pc[31:2], 2'b00};
      end else begin
        drop_pending = 1'b0;
        exp_req_pc   = {i_redirect_pc[31:2], 2'b00};
      end
    end
    @(negedge clk);
    avail = sb.size() - pushed_now;
    chk("inst_valid", o_inst_valid, avail > 0);
    if (o_inst_valid && i_inst_ready && avail > 0) begin
      e = sb.pop_front();
      chk("inst_pc", o_inst_pc, e[63:32]);
      chk("inst", o_inst, e[31:0]);
    end
    if (i_redirect_valid) sb.delete();
    if (!rst) begin
      sb.delete();
      exp_req_pc   = RST_PC;
      drop_pending = 1'b0;
    end
    @(posedge clk);
    if (!rst || ack_now) wait_cnt = 0;
    else if (req_now) wait_cnt++;
    #1;
    i_imem_ack       = 1'b0;
    i_redirect_valid = 1'b0;
    rogue_ack        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_inst_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle();
    chk("rst_req", o_imem_req, 0);
    chk("rst_addr", o_imem_addr, RST_PC);
    chk("rst_valid", o_inst_valid, 0);
    chk("rst_inst", o_inst, 0);
    chk("rst_inst_pc", o_inst_pc, 0);

    // Release: IDLE one cycle, then back-to-back zero-latency fetches.
    rst = 1'b1;
    chk("idle_req", o_imem_req, 0);
    cycle();
    chk("first_req", o_imem_req, 1);
    chk("first_addr", o_imem_addr, RST_PC);
    chk("valid_pre_ack", o_inst_valid, 0);
    cycle();
    chk("valid_rise", o_inst_valid, 1);
    acks0 = n_acks;
    repeat (6) cycle();
    chk("throughput_acks", n_acks - acks0, 6);

    // Three-cycle ack latency: one request per four cycles.
    mem_lat = 3;
    acks0 = n_acks;
    repeat (12) cycle();
    chk("lat3_acks", n_acks - acks0, 3);

    // Back-pressure into STALL, single-cycle release.
    mem_lat = 0;
    i_inst_ready = 1'b0;
    repeat (4) cycle();
    chk("stall_req", o_imem_req, 0);
    chk("stall_valid", o_inst_valid, 1);
    i_inst_ready = 1'b1;
    cycle();
    i_inst_ready = 1'b0;
    chk("resume_req", o_imem_req, 1);
    cycle();
    chk("restall_req", o_imem_req, 0);
    i_inst_ready = 1'b1;
    repeat (4) cycle();

    // Redirect while the request for 0x8 is pending.
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    mem_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (o_imem_req && exp_req_pc == 32'h8 && wait_cnt == 1) found = 1'b1;
      else cycle();
    end
    chk("find_req8", found, 1);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0100;
    cycle();
    chk("drop_addr", o_imem_addr, 32'h8);
    for (int i = 0; i < 20 && !o_inst_valid; i++) cycle();
    chk("redir_first_pc", o_inst_pc, 32'h100);
    repeat (2) cycle();

    // Redirect while stalled with a full buffer.
    mem_lat = 0;
    i_inst_ready = 1'b0;
    repeat (4) cycle();
    chk("full_stall_req", o_imem_req, 0);
    chk("full_stall_valid", o_inst_valid, 1);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0203;
    cycle();
    chk("flush_valid", o_inst_valid, 0);
    chk("flush_req", o_imem_req, 1);
    chk("flush_addr", o_imem_addr, 32'h200);
    i_inst_ready = 1'b1;
    repeat (4) cycle();

    // PC wraps past the top of the address space.
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFE;
    cycle();
    chk("wrap_start", o_imem_addr, 32'hFFFF_FFFC);
    repeat (2) cycle();
    chk("wrap_addr", o_imem_addr, 32'h4);

    // Reset with a request outstanding, then a stray ack.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_imem_req && wait_cnt == 1) found = 1'b1;
      else cycle();
    end
    chk("find_outstanding", found, 1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("midrst_req", o_imem_req, 0);
    chk("midrst_valid", o_inst_valid, 0);
    rogue_ack = 1'b1;
    cycle();
    chk("late_ack_valid", o_inst_valid, 0);
    chk("restart_req", o_imem_req, 1);
    chk("restart_addr", o_imem_addr, RST_PC);
    mem_lat = 0;
    repeat (5) cycle();

    // Drain with memory silent; everything fetched must have been delivered.
    mem_lat = 1000;
    repeat (4) cycle();
    chk("sb_empty", sb.size(), 0);
    chk("final_valid", o_inst_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
